// File: rtl/pipe_pkg.sv
// Pipeline-wide constants: opcodes, the bubble word, instruction field positions
// and the fetch-stage state encoding.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b010101;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b100001;
    localparam logic [5:0] OP_BEQ   = 6'b010001;
    localparam logic [5:0] OP_BNE   = 6'b110001;
    localparam logic [5:0] OP_NOP   = 6'b001111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_000F;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 5;
    localparam int PPP_LSB    = 21;
    localparam int PPP_MSB    = 23;
    localparam int WW_LSB     = 24;
    localparam int WW_MSB     = 25;
    localparam int FUNC_LSB   = 26;
    localparam int FUNC_MSB   = 31;
    localparam int IMM_LSB    = 16;
    localparam int IMM_MSB    = 31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory req/gnt port, ID-stage stall/redirect inputs
// and the IF/ID register outputs. master = fetch unit, slave = memory/ID side.
interface fetch_unit_if #(
    parameter int unsigned PC_W = 10
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            id_stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic [31:0]     if2id_instr;
    logic [PC_W-1:0] if2id_pc;
    logic            if2id_valid;
    logic            if2id_flush;

    modport master (
        output imem_req, imem_addr, if2id_instr, if2id_pc, if2id_valid, if2id_flush,
        input  imem_gnt, imem_rvalid, imem_rdata, id_stall, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, if2id_instr, if2id_pc, if2id_valid, if2id_flush,
        output imem_gnt, imem_rvalid, imem_rdata, id_stall, br_taken, br_target
    );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry in-order queue of returned {instr, pc} words; zero-latency head output.
// clear wins over push/pop; a push into a full queue is taken only alongside a pop.
module fetch_buf #(
    parameter int unsigned DATA_W = 42
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] push_dat_i,
    output logic [DATA_W-1:0] head_dat_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        count_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o    = (count_q == 2'd0);
    assign full_o     = (count_q == 2'd2);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, req/gnt fetch, 2-entry return queue with same-cycle bypass into IF/ID (first valid 3 cycles after reset).
// Requests stop while queued + in-flight words reach 2; a redirect clears the queue, drops the in-flight word and inserts one flush bubble.
module fetch_unit #(
    parameter int unsigned     PC_W      = 10,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_000F
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    import pipe_pkg::*;

    localparam int unsigned ENT_W = 32 + PC_W;

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            inflight_q;
    logic [PC_W-1:0] inflight_pc_q;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] id_pc_q;
    logic            valid_q;
    logic            flush_q;

    logic             buf_push;
    logic             buf_pop;
    logic             buf_full;
    logic             buf_empty;
    logic [1:0]       buf_count;
    logic [ENT_W-1:0] buf_head;
    logic [2:0]       in_use;
    logic             req;
    logic             fire;
    logic             rv_ok;
    logic             bypass;

    fetch_buf #(.DATA_W(ENT_W)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (buf_push),
        .pop_i      (buf_pop),
        .clear_i    (bus.br_taken),
        .push_dat_i ({bus.imem_rdata, inflight_pc_q}),
        .head_dat_o (buf_head),
        .full_o     (buf_full),
        .empty_o    (buf_empty),
        .count_o    (buf_count)
    );

    // The in-flight word always has a queue slot reserved, so the queue can never overflow.
    assign in_use = {1'b0, buf_count} + {2'b00, inflight_q};
    assign req    = (state_q != ST_IDLE) && !buf_full && (in_use < 3'd2);
    assign fire   = req && bus.imem_gnt;
    assign rv_ok  = bus.imem_rvalid && (state_q != ST_DRAIN) && !bus.br_taken;
    assign bypass = rv_ok && buf_empty && !bus.id_stall;
    assign buf_push = rv_ok && !bypass;
    assign buf_pop  = !bus.id_stall && !buf_empty;

    always_comb begin
        pc_d = pc_q;
        if (bus.br_taken) begin
            pc_d = bus.br_target;
        end else if (fire) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            instr_q       <= NOP_INSTR;
            id_pc_q       <= '0;
            valid_q       <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= fire;
            if (fire) begin
                inflight_pc_q <= pc_q;
            end

            // DRAIN marks that the next returned word belongs to the wrong path.
            case (state_q)
                ST_IDLE: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.br_taken && (inflight_q || fire)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.br_taken && (inflight_q || fire)) begin
                        state_q <= ST_DRAIN;
                    end else if (bus.imem_rvalid || !inflight_q) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (bus.br_taken) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
                flush_q <= 1'b1;
            end else if (!bus.id_stall) begin
                flush_q <= 1'b0;
                if (!buf_empty) begin
                    {instr_q, id_pc_q} <= buf_head;
                    valid_q            <= 1'b1;
                end else if (bypass) begin
                    instr_q <= bus.imem_rdata;
                    id_pc_q <= inflight_pc_q;
                    valid_q <= 1'b1;
                end else begin
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.if2id_instr = instr_q;
    assign bus.if2id_pc    = id_pc_q;
    assign bus.if2id_valid = valid_q;
    assign bus.if2id_flush = flush_q;

endmodule
